// File: rtl/scale_sequencer.sv
// scale_sequencer: steps through the notes enabled in a latched switch mask,
// sounding each for BEAT_CYCLES clocks followed by GAP_CYCLES clocks of silence.
// Order is ascending, or ascending-then-descending (C5 sounded once), with
// optional looping sampled live at each sequence end.
//
// Handshake: start is a level sampled only in IDLE; it is accepted when
// start=1, stop=0 and sw!=0 on the same edge. stop aborts from any non-IDLE
// state on the next edge and takes priority over start and sequence end.
// done is a single-cycle pulse in the first IDLE cycle after a non-looping
// sequence completes.
module scale_sequencer #(
  parameter int unsigned BEAT_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 1250000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] sw,
  input  logic       updown,
  input  logic       loop,
  output logic [7:0] note_en,
  output logic [2:0] step_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Terminal counts; the counter runs 0..N-1 inside each timed state.
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LAST  =
    CNT_W'((GAP_CYCLES > 32'd0) ? (GAP_CYCLES - 32'd1) : 32'd0);

  // Direction encoding: 0 = up (towards C5), 1 = down (towards C4).
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // State is kept visible as a typed signal so checkers can bind to it.
  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             dir_q, dir_d;
  logic [7:0]       mask_q, mask_d;
  logic             updown_q, updown_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       note_en_q, note_en_d;
  logic             done_q, done_d;

  // Advance decision for the current index/direction.
  logic [2:0] adv_idx;
  logic       adv_dir;
  logic       adv_end;

  // Registered state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      dir_q     <= DIR_UP;
      mask_q    <= 8'h00;
      updown_q  <= 1'b0;
      cnt_q     <= '0;
      note_en_q <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dir_q     <= dir_d;
      mask_q    <= mask_d;
      updown_q  <= updown_d;
      cnt_q     <= cnt_d;
      note_en_q <= note_en_d;
      done_q    <= done_d;
    end
  end

  // Where the next note lies; at the top an up/down run turns around at 6
  // so C5 is not repeated.
  always_comb begin
    adv_idx = idx_q;
    adv_dir = dir_q;
    adv_end = 1'b0;
    if (dir_q == DIR_UP) begin
      if (idx_q != 3'd7) begin
        adv_idx = idx_q + 3'd1;
      end else if (updown_q) begin
        adv_idx = 3'd6;
        adv_dir = DIR_DOWN;
      end else begin
        adv_end = 1'b1;
      end
    end else begin
      if (idx_q != 3'd0) begin
        adv_idx = idx_q - 3'd1;
      end else begin
        adv_end = 1'b1;
      end
    end
  end

  // Next-state and output logic for the sequencer FSM.
  always_comb begin
    logic adv;
    adv       = 1'b0;
    state_d   = state_q;
    idx_d     = idx_q;
    dir_d     = dir_q;
    mask_d    = mask_q;
    updown_d  = updown_q;
    cnt_d     = cnt_q;
    note_en_d = note_en_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        note_en_d = 8'h00;
        if (start && !stop && (sw != 8'h00)) begin
          mask_d   = sw;
          updown_d = updown;
          idx_d    = 3'd0;
          dir_d    = DIR_UP;
          cnt_d    = '0;
          state_d  = ST_SEEK;
        end
      end
      ST_SEEK: begin
        if (mask_q[3'd7 - idx_q]) begin
          state_d   = ST_PLAY;
          cnt_d     = '0;
          note_en_d = 8'h80 >> idx_q;
        end else begin
          adv = 1'b1;
        end
      end
      ST_PLAY: begin
        if (cnt_q == BEAT_LAST) begin
          note_en_d = 8'h00;
          cnt_d     = '0;
          if (GAP_CYCLES == 32'd0) begin
            adv = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          adv   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        note_en_d = 8'h00;
      end
    endcase

    // Move to the next note, or finish/loop the sequence.
    if (adv) begin
      cnt_d = '0;
      if (!adv_end) begin
        idx_d   = adv_idx;
        dir_d   = adv_dir;
        state_d = ST_SEEK;
      end else if (loop) begin
        idx_d   = 3'd0;
        dir_d   = DIR_UP;
        state_d = ST_SEEK;
      end else begin
        idx_d   = 3'd0;
        dir_d   = DIR_UP;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end

    // Abort overrides everything else that happened this cycle.
    if (stop && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      idx_d     = 3'd0;
      dir_d     = DIR_UP;
      cnt_d     = '0;
      note_en_d = 8'h00;
      done_d    = 1'b0;
    end
  end

  assign note_en  = note_en_q;
  assign step_idx = idx_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: doc/scale_sequencer.md
Name: scale_sequencer

Overview:
- Automatic note sequencer for the FPGA piano; drives the eight note-enable lines that gate the C4..C5 square-wave generators.
- On `start`, steps through the notes enabled in the latched switch mask: each note sounds for BEAT_CYCLES, followed by a GAP_CYCLES silence.
- Supports ascending, or ascending-then-descending, order, with optional looping.
- Replaces manual switch playing while the "play octave" button function is active.

Parameters:
- BEAT_CYCLES, 12500000, clk cycles each note sounds (0.5 s at 25 MHz); must be >= 1.
- GAP_CYCLES, 1250000, clk cycles of silence after each note; 0 means no gap.
- CNT_W, 32, width of the beat/gap counter; must hold max(BEAT_CYCLES, GAP_CYCLES).

Ports:
- clk  in  1  system clock, 25 MHz.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- stop  in  1  abort the sequence; synchronous.
- sw  in  8  note mask; sw[7]=C4 ... sw[0]=C5; latched on accepted start.
- updown  in  1  0: ascending only; 1: ascending then descending. Latched on accepted start.
- loop  in  1  1: restart the sequence at its end. Sampled live at each sequence end.
- note_en  out  8  one-hot enable (bit mapping as sw), or 0 when silent. Registered.
- step_idx  out  3  current note index; 0=C4 ... 7=C5. Bit for index i is 7-i.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a non-looping sequence completes.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset, and any cycle with rst=1: state=IDLE, note_en=0, step_idx=0, busy=0, done=0, counter=0, latched mask=0, direction=up. Reset mid-play silences the outputs on the next edge.
- States: IDLE, SEEK, PLAY, GAP.
- IDLE:
  - done is low except in the first IDLE cycle after completion.
  - start=1 with sw!=0 and stop=0: latch sw and updown, idx=0, dir=up, go to SEEK.
  - start with sw==0: ignored, remain IDLE.
- SEEK (1 cycle, note_en=0):
  - If latched mask bit (7-idx) is set: go to PLAY, counter=0, note_en=one-hot(7-idx).
  - Otherwise: advance (see below) and stay in SEEK.
  - Each skipped note costs exactly 1 cycle.
- PLAY: note_en held for exactly BEAT_CYCLES cycles. Then go to GAP with counter=0, or straight to advance if GAP_CYCLES=0.
- GAP: note_en=0 for exactly GAP_CYCLES cycles, then advance.
- Advance (from GAP end, or from SEEK on a skipped note):
  - Up and idx<7: idx+1, go to SEEK.
  - Up and idx==7:
    - updown=1: dir=down, idx=6, go to SEEK. C5 is played once only.
    - updown=0: sequence end.
  - Down and idx>0: idx-1, go to SEEK.
  - Down and idx==0: sequence end.
- Sequence end:
  - loop=1: idx=0, dir=up, go to SEEK. done stays 0.
  - loop=0: go to IDLE and pulse done=1 for one cycle.
- Nominal note period with all notes enabled: 1 + BEAT_CYCLES + GAP_CYCLES cycles.
- stop=1 in any non-IDLE state: next edge gives IDLE, note_en=0, busy=0, done=0. stop wins over start and over sequence end in the same cycle.
- start while busy: ignored. sw and updown changes while busy: no effect until the next accepted start.
- Counter compares against the parameter minus 1; no wrap is possible within CNT_W.

Test Plan:
Bench uses BEAT_CYCLES=4, GAP_CYCLES=2, with rst pulsed first.
1. Ascending, full mask: sw=FF, updown=0, loop=0, start for 1 cycle -> note_en sequence 80,40,20,10,08,04,02,01. Each value held 4 cycles, separated by 3 zero cycles (SEEK+GAP). done pulses once at cycle 57 after the start edge, then busy=0.
2. Sparse mask: sw=A5 -> note_en 80,20,04,01 only. Each skipped note adds 1 cycle of silence; step_idx reads 0,2,5,7 during PLAY.
3. Up-down: sw=FF, updown=1 -> 15 notes: 80..01 then 02..80. C5 (01) played once; done after the final 80.
4. Loop and stop: loop=1 -> after 01, 80 follows with no done pulse. Assert stop mid-PLAY -> note_en=00 and busy=0 the next cycle, done stays 0.
5. Ignored inputs:
   - start with sw=00 -> busy stays 0.
   - Mid-sequence sw=00 and a start pulse -> sequence continues unchanged with the original mask.
6. Reset during PLAY of note 40 -> next cycle note_en=00, step_idx=0, busy=0. A fresh start then plays from 80.
